// File: rtl/bram_wr.sv
// Packs pairs of 16-bit samples into 32-bit words and writes a burst of them into a BRAM port.
// Latency: the BRAM write occurs one cycle after the high-half sample is accepted, so peak throughput is 2 samples per 3 cycles.
// Backpressure: din_ready is high only while waiting for a low or high half; a din_valid gap stalls the block with no side effects.
module bram_wr #(
   parameter int unsigned DEPTH_WORDS = 2048,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_wr,
   input  logic [11:0] wr_len,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        busy,
   output logic        done,
   output logic        ram_clk,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wr_data,
   output logic        ram_rst
);

   // Index covers 0..DEPTH_WORDS-1; the length must also hold DEPTH_WORDS itself.
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int LW = $clog2(DEPTH_WORDS + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LO    = 3'd1,
      HI    = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [LW-1:0] len_q, len_d;
   logic [31:0]   pack_q, pack_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;

   // State and datapath registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         pack_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         pack_q  <= pack_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic; address and data are loaded on the high-half accept so
   // they are already stable in WRITE and simply hold afterwards.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      pack_d  = pack_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start_wr && (wr_len != 12'd0)) begin
               // Clip oversize requests so the index can never wrap the BRAM.
               if (32'(wr_len) > DEPTH_WORDS) begin
                  len_d = LW'(DEPTH_WORDS);
               end else begin
                  len_d = LW'(wr_len);
               end
               idx_d   = '0;
               state_d = LO;
            end
         end
         LO: begin
            if (din_valid) begin
               pack_d[15:0] = din;
               state_d      = HI;
            end
         end
         HI: begin
            if (din_valid) begin
               pack_d[31:16] = din;
               data_d        = {din, pack_q[15:0]};
               addr_d        = BASE_ADDR + (32'(idx_q) << 2);
               state_d       = WRITE;
            end
         end
         WRITE: begin
            idx_d = idx_q + IW'(1);
            if ((32'(idx_q) + 32'd1) == 32'(len_q)) begin
               state_d = DONE;
            end else begin
               state_d = LO;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status and strobes are decoded from state and forced low while reset is held.
   always_comb begin
      din_ready = ((state_q == LO) || (state_q == HI)) && !rst;
      busy      = ((state_q == LO) || (state_q == HI) || (state_q == WRITE)) && !rst;
      done      = (state_q == DONE) && !rst;
      ram_en    = (state_q == WRITE) && !rst;
      ram_we    = {4{ram_en}};
   end

   assign ram_clk     = clk;
   assign ram_rst     = 1'b0;
   assign ram_addr    = addr_q;
   assign ram_wr_data = data_q;

endmodule

// File: tb/tb_bram_wr.sv
// Self-checking bench for bram_wr: random samples and gaps, with the expected write list computed from burst length.
// Latency: checks each write one cycle after its high-half sample is accepted.
// Backpressure: drives din_valid with random gaps and follows din_ready.
module tb_bram_wr;

   logic        clk;
   logic        rst;
   logic        start_wr;
   logic [11:0] wr_len;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic        busy;
   logic        done;
   logic        ram_clk;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wr_data;
   logic        ram_rst;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] wq_addr[$];
   logic [31:0] wq_data[$];
   int          done_cnt;
   logic [15:0] samp[4096];

   bram_wr #(.DEPTH_WORDS(2048), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .start_wr(start_wr), .wr_len(wr_len),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .busy(busy), .done(done), .ram_clk(ram_clk), .ram_en(ram_en),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
      .ram_rst(ram_rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: log every BRAM write, count done pulses, check strobe consistency.
   always @(negedge clk) begin
      if (ram_en === 1'b1) begin
         wq_addr.push_back(ram_addr);
         wq_data.push_back(ram_wr_data);
      end
      if (done === 1'b1) done_cnt++;
      n_cmp++;
      if (ram_we !== (ram_en === 1'b1 ? 4'hF : 4'h0) || ram_rst !== 1'b0) begin
         n_err++;
         $display("FAIL strobe: en=%b we=%h ram_rst=%b (need we=F only with en, ram_rst=0)", ram_en, ram_we, ram_rst);
      end
   end

   task automatic fill_random();
      for (int i = 0; i < 4096; i++) samp[i] = 16'($urandom);
   endtask

   // One burst: request len words, stream samples with gap_pct% idle cycles,
   // optionally pulsing start_wr (wr_len=5) once sample index start_at is reached.
   task automatic run_burst(input logic [11:0] len, input int gap_pct, input int start_at, input string name);
      int words;
      int nsamp;
      int k;
      int budget;
      logic acc;
      logic [31:0] ea;
      logic [31:0] ed;
      words  = (int'(len) > 2048) ? 2048 : int'(len);
      nsamp  = 2 * words;
      k      = 0;
      wq_addr.delete();
      wq_data.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start_wr = 1'b1; wr_len = len;
      @(posedge clk); #1;
      start_wr = 1'b0;
      budget = 20 * nsamp + 50;
      while (k < nsamp && budget > 0) begin
         din_valid = ($urandom_range(0, 99) >= gap_pct);
         din       = samp[k];
         start_wr  = (start_at >= 0) && (k == start_at);
         wr_len    = (start_at >= 0) ? 12'd5 : len;
         @(negedge clk);
         acc = din_ready && din_valid;
         @(posedge clk); #1;
         din_valid = 1'b0;
         start_wr  = 1'b0;
         if (acc) begin
            k++;
            if (k % 2 == 0) begin
               ea = 32'(4 * (k / 2 - 1));
               ed = {samp[k-1], samp[k-2]};
               n_cmp++;
               if (ram_en !== 1'b1 || ram_addr !== ea || ram_wr_data !== ed) begin
                  n_err++;
                  $display("FAIL %s write_latency: en=%b addr=%h data=%h need en=1 addr=%h data=%h", name, ram_en, ram_addr, ram_wr_data, ea, ed);
               end
            end
         end
         budget--;
      end
      n_cmp++;
      if (k != nsamp) begin
         n_err++;
         $display("FAIL %s feed_timeout: accepted %0d samples, need %0d", name, k, nsamp);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (wq_addr.size() != words) begin
         n_err++;
         $display("FAIL %s write_count: got %0d writes, need %0d", name, wq_addr.size(), words);
      end
      for (int i = 0; i < words && i < wq_addr.size(); i++) begin
         n_cmp++;
         if (wq_addr[i] !== 32'(4 * i) || wq_data[i] !== {samp[2*i+1], samp[2*i]}) begin
            n_err++;
            $display("FAIL %s write[%0d]: addr=%h data=%h need addr=%h data=%h", name, i, wq_addr[i], wq_data[i], 32'(4 * i), {samp[2*i+1], samp[2*i]});
         end
      end
      n_cmp++;
      if (done_cnt != 1 || busy !== 1'b0 || din_ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s done_busy: done pulses=%0d busy=%b ready=%b, need 1/0/0", name, done_cnt, busy, din_ready);
      end
      n_cmp++;
      if (ram_addr !== 32'(4 * (words - 1)) || ram_wr_data !== {samp[2*words-1], samp[2*words-2]}) begin
         n_err++;
         $display("FAIL %s hold: addr=%h data=%h need last written values", name, ram_addr, ram_wr_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({din_ready, busy, done, ram_en, ram_we, ram_rst} !== 9'd0 || ram_addr !== 32'd0 || ram_wr_data !== 32'd0) begin
         n_err++;
         $display("FAIL reset: ready=%b busy=%b done=%b en=%b we=%h addr=%h data=%h need all 0", din_ready, busy, done, ram_en, ram_we, ram_addr, ram_wr_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 6; i++) samp[i] = 16'(i + 1);
      run_burst(12'd3, 0, -1, "basic");
      n_cmp++;
      if (wq_data.size() != 3 || wq_data[0] !== 32'h0002_0001 || wq_data[2] !== 32'h0006_0005 || wq_addr[2] !== 32'h8) begin
         n_err++;
         $display("FAIL basic_vector: first/last data/addr not 00020001/00060005 @8");
      end
   endtask

   task automatic test_gaps();
      fill_random();
      run_burst(12'd1, 50, -1, "gaps");
   endtask

   task automatic test_random();
      for (int b = 0; b < 3; b++) begin
         fill_random();
         run_burst(12'($urandom_range(1, 20)), 40, -1, "random");
      end
   endtask

   task automatic test_clip();
      fill_random();
      run_burst(12'hFFF, 0, -1, "clip");
      n_cmp++;
      if (wq_addr.size() == 0 || wq_addr[wq_addr.size()-1] !== 32'h0000_1FFC) begin
         n_err++;
         $display("FAIL clip_last_addr: last write addr not 00001ffc (writes=%0d)", wq_addr.size());
      end
   endtask

   task automatic test_ignore_start();
      fill_random();
      run_burst(12'd3, 20, 3, "ignore_start");
   endtask

   task automatic test_mid_reset();
      int budget;
      fill_random();
      wq_addr.delete();
      wq_data.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start_wr = 1'b1; wr_len = 12'd4;
      @(posedge clk); #1;
      start_wr = 1'b0; din = samp[0]; din_valid = 1'b1;
      budget = 10;
      @(negedge clk);
      while (!(din_ready === 1'b1) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({din_ready, busy, done, ram_en, ram_we} !== 8'd0) begin
         n_err++;
         $display("FAIL mid_reset_outputs: ready=%b busy=%b done=%b en=%b we=%h need 0", din_ready, busy, done, ram_en, ram_we);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (ram_addr !== 32'd0 || ram_wr_data !== 32'd0 || wq_addr.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL mid_reset_state: addr=%h data=%h writes=%0d busy=%b need 0/0/0/0", ram_addr, ram_wr_data, wq_addr.size(), busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      fill_random();
      run_burst(12'd1, 0, -1, "after_reset");
   endtask

   task automatic test_zero_len();
      int bad;
      bad = 0;
      wq_addr.delete();
      wq_data.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start_wr = 1'b1; wr_len = 12'd0; din_valid = 1'b1;
      @(posedge clk); #1;
      start_wr = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy !== 1'b0 || din_ready !== 1'b0) bad++;
      end
      din_valid = 1'b0;
      n_cmp++;
      if (bad != 0 || done_cnt != 0 || wq_addr.size() != 0) begin
         n_err++;
         $display("FAIL zero_len: busy/ready-high cycles=%0d done=%0d writes=%0d need 0/0/0", bad, done_cnt, wq_addr.size());
      end
   endtask

   initial begin
      rst = 1'b1; start_wr = 1'b0; wr_len = 12'd0; din = 16'd0; din_valid = 1'b0;
      done_cnt = 0;
      test_reset();
      test_basic();
      test_gaps();
      test_random();
      test_ignore_start();
      test_mid_reset();
      test_zero_len();
      test_clip();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bram_wr.md
BRAM_WR -- requirements
Module: bram_wr

Interface
REQ-001 Parameter DEPTH_WORDS, default 2048: BRAM capacity in 32-bit words (8192 bytes).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 clk  input  1  single clock for all logic; ram_clk is driven from it.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_wr  input  1  one-cycle request to begin a capture burst.
REQ-006 wr_len  input  12  number of 32-bit words to write, sampled on an accepted start_wr.
REQ-007 din  input  16  sample to store.
REQ-008 din_valid  input  1  din holds a valid sample this cycle.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 busy  output  1  burst in progress.
REQ-011 done  output  1  one-cycle pulse after the last word is written.
REQ-012 ram_clk  output  1  BRAM port clock, equal to clk.
REQ-013 ram_en  output  1  BRAM enable.
REQ-014 ram_we  output  4  BRAM byte write enables.
REQ-015 ram_addr  output  32  BRAM byte address.
REQ-016 ram_wr_data  output  32  BRAM write data.
REQ-017 ram_rst  output  1  BRAM reset, tied to constant 0.

Function
REQ-018 The FSM SHALL have the states IDLE, LO, HI, WRITE and DONE.
REQ-019 In IDLE, start_wr=1 with wr_len!=0 SHALL latch len=min(wr_len, DEPTH_WORDS), clear the word index, and move to LO; start_wr with wr_len=0 SHALL be ignored.
REQ-020 start_wr asserted in any state other than IDLE SHALL be ignored.
REQ-021 din_ready SHALL be 1 only in LO and HI; a sample is accepted when din_valid and din_ready are both 1.
REQ-022 An accepted sample in LO SHALL be stored in bits [15:0] of the packing register, and the FSM SHALL move to HI.
REQ-023 An accepted sample in HI SHALL be stored in bits [31:16], and the FSM SHALL move to WRITE.
REQ-024 In WRITE, for exactly one cycle, the block SHALL drive ram_en=1, ram_we=4'hF, ram_wr_data={hi,lo} and ram_addr=BASE_ADDR+4*index.
REQ-025 The write SHALL occur in the cycle after the HI sample is accepted (latency 1); peak throughput is 2 samples per 3 cycles.
REQ-026 Outside WRITE, ram_en and ram_we SHALL be 0, and ram_addr and ram_wr_data SHALL hold their last values.
REQ-027 After WRITE, the index SHALL increment; if index+1==len the FSM SHALL go to DONE, otherwise it SHALL go to LO.
REQ-028 The index SHALL never exceed DEPTH_WORDS-1; any wr_len above DEPTH_WORDS is clipped, so no address wrap occurs within a burst.
REQ-029 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-030 busy SHALL be 1 in LO, HI and WRITE, and 0 in IDLE and DONE.
REQ-031 din_valid gaps SHALL stall the FSM in LO or HI with no side effects.
REQ-032 ram_addr arithmetic SHALL be 32-bit unsigned, with the index shifted left by 2.

Reset
REQ-033 While rst=1 at a clk edge, the state SHALL become IDLE and the index, len, packing register, ram_addr and ram_wr_data SHALL become 0.
REQ-034 While rst=1, din_ready, busy, done, ram_en and ram_we SHALL all be 0; ram_rst SHALL be 0 at all times.
REQ-035 A reset mid-burst SHALL discard any partial word with no further BRAM write, and the next burst SHALL start from index 0.

Verification
REQ-036 wr_len=3; din 16'h0001..16'h0006 on consecutive valid cycles -> three writes: addr 0x0 data 0x00020001, addr 0x4 data 0x00040003, addr 0x8 data 0x00060005; done pulses once; busy then falls.
REQ-037 wr_len=1; din_valid toggled every other cycle -> exactly one write, of {second,first}, with ram_we=4'hF for one cycle only.
REQ-038 wr_len=12'hFFF -> clipped to 2048 words; last write at addr 0x1FFC; done follows; no write at 0x2000.
REQ-039 start_wr pulsed mid-burst with wr_len=5 -> ignored; the original length completes unchanged.
REQ-040 rst asserted in HI after one sample -> no write occurs and all outputs are 0; a new burst with wr_len=1 writes to addr 0x0.
REQ-041 start_wr with wr_len=0 -> busy stays 0, no done pulse, no BRAM activity.
